// File: rtl/load_ext_32_pkg.sv
// Shared encodings for the load-extend path: access sizes, FSM states and
// the alignment rule used to reject bad accesses before touching memory.
package load_ext_32_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    FAIL = 2'b11
  } state_t;

  // The reserved size encoding counts as misaligned so it never reaches memory.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_ext_32_if.sv
// Word-read port between the load unit (master) and data memory (slave).
interface load_ext_32_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/load_ext_32_lane_ext.sv
// Picks the little-endian byte/halfword lane out of a memory word and
// sign- or zero-extends it to 32 bits; shared by any load path.
module lane_ext_32
  import load_ext_32_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{a, 3'b000} +: 8];
    half_lane = a[1] ? word[31:16] : word[15:0];
    ext       = '0;
    case (size)
      SZ_BYTE: ext = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: ext = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      SZ_WORD: ext = word;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/load_ext_32.sv
// Load unit: fetches a word over a req/ack port, extracts and extends the
// addressed lane, and reports misalignment or acknowledge timeout via err.
module load_ext_32
  import load_ext_32_pkg::*;
#(
  parameter int TIMEOUT = 16
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        addr,
  input  logic [1:0]         size,
  input  logic               is_unsigned,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        data_out,
  load_ext_32_if.master      mem
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT   = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    lat_a, lat_a_nxt;
  logic [1:0]    lat_size, lat_size_nxt;
  logic          lat_uns, lat_uns_nxt;
  logic [31:0]   data_nxt;
  logic [31:0]   maddr_q, maddr_nxt;
  logic          req_q;
  logic [31:0]   ext_val;

  lane_ext_32 u_lane (
    .word        (mem.rdata),
    .a           (lat_a),
    .size        (lat_size),
    .is_unsigned (lat_uns),
    .ext         (ext_val)
  );

  assign mem.req  = req_q;
  assign mem.addr = maddr_q;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_a_nxt    = lat_a;
    lat_size_nxt = lat_size;
    lat_uns_nxt  = lat_uns;
    data_nxt     = data_out;
    maddr_nxt    = maddr_q;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          lat_a_nxt    = addr[1:0];
          lat_size_nxt = size;
          lat_uns_nxt  = is_unsigned;
          maddr_nxt    = {addr[31:2], 2'b00};
          if (misaligned(size, addr[1:0])) begin
            state_nxt = FAIL;
            data_nxt  = '0;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (mem.ack) begin
          data_nxt  = ext_val;
          state_nxt = RESP;
        end else if ((TIMEOUT != 0) && (cnt == LIMIT)) begin
          data_nxt  = '0;
          state_nxt = FAIL;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      FAIL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // done/err lag the completion state by one edge so every output stays a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_a    <= '0;
      lat_size <= '0;
      lat_uns  <= 1'b0;
      data_out <= '0;
      maddr_q  <= '0;
      req_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lat_a    <= lat_a_nxt;
      lat_size <= lat_size_nxt;
      lat_uns  <= lat_uns_nxt;
      data_out <= data_nxt;
      maddr_q  <= maddr_nxt;
      req_q    <= (state_nxt == REQ);
      busy     <= (state_nxt != IDLE);
      done     <= (state == RESP) || (state == FAIL);
      err      <= (state == FAIL);
    end
  end

endmodule

// File: tb/tb_load_ext_32.sv
// Directed self-checking bench for load_ext_32 with a hand-driven memory port.
module tb_load_ext_32;
  import load_ext_32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  size = '0;
  logic        is_unsigned = 1'b0;
  logic        busy, done, err;
  logic [31:0] data_out;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  load_ext_32_if mem_bus();

  load_ext_32 #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .addr        (addr),
    .size        (size),
    .is_unsigned (is_unsigned),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .data_out    (data_out),
    .mem         (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait load: START, ack on the next edge, return outputs in the DONE cycle.
  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [31:0] rd, output logic [31:0] d,
                          output logic dn, output logic er);
    addr = a; size = sz; is_unsigned = u; start = 1'b1;
    tick();
    start = 1'b0;
    mem_bus.ack = 1'b1; mem_bus.rdata = rd;
    tick();
    mem_bus.ack = 1'b0;
    tick();
    d = data_out; dn = done; er = err;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, err, mem_bus.req} !== 4'b0000)
      $display("[TB] FAIL reset_flags got %b want 0000", {busy, done, err, mem_bus.req});
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 32'h0) $display("[TB] FAIL reset_data got %h want 00000000", data_out);
    else pass_cnt++;
    total_cnt++;
    if (mem_bus.addr !== 32'h0) $display("[TB] FAIL reset_maddr got %h want 00000000", mem_bus.addr);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_byte_signed();
    addr = 32'h103; size = SZ_BYTE; is_unsigned = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (mem_bus.req !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL byte_req got req=%b busy=%b want 1 1", mem_bus.req, busy);
    else pass_cnt++;
    total_cnt++;
    if (mem_bus.addr !== 32'h100) $display("[TB] FAIL byte_maddr got %h want 00000100", mem_bus.addr);
    else pass_cnt++;
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h80FF1234;
    tick();
    mem_bus.ack = 1'b0;
    total_cnt++;
    if (done !== 1'b0 || mem_bus.req !== 1'b0)
      $display("[TB] FAIL byte_early got done=%b req=%b want 0 0", done, mem_bus.req);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b1 || err !== 1'b0)
      $display("[TB] FAIL byte_done got done=%b err=%b want 1 0", done, err);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 32'hFFFFFF80) $display("[TB] FAIL byte_data got %h want ffffff80", data_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0) $display("[TB] FAIL byte_pulse got done=%b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_half_wait();
    int req_cycles = 0;
    addr = 32'h202; size = SZ_HALF; is_unsigned = 1'b1; start = 1'b1;
    mem_bus.rdata = 32'hBEEF0001;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mem_bus.req === 1'b1) req_cycles++;
      tick();
    end
    if (mem_bus.req === 1'b1) req_cycles++;
    mem_bus.ack = 1'b1;
    tick();
    mem_bus.ack = 1'b0;
    total_cnt++;
    if (req_cycles != 4 || mem_bus.req !== 1'b0)
      $display("[TB] FAIL half_req_len got %0d req=%b want 4 0", req_cycles, mem_bus.req);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b1 || err !== 1'b0)
      $display("[TB] FAIL half_done got done=%b err=%b want 1 0", done, err);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 32'h0000BEEF) $display("[TB] FAIL half_data got %h want 0000beef", data_out);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_misaligned();
    logic [31:0] va [2] = '{32'h301, 32'h300};
    logic [1:0]  vs [2] = '{SZ_WORD, 2'b11};
    for (int i = 0; i < 2; i++) begin
      addr = va[i]; size = vs[i]; is_unsigned = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      total_cnt++;
      if (mem_bus.req !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
        $display("[TB] FAIL misal_%0d_first got req=%b done=%b busy=%b want 0 0 1", i, mem_bus.req, done, busy);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done !== 1'b1 || err !== 1'b1 || data_out !== 32'h0 || mem_bus.req !== 1'b0)
        $display("[TB] FAIL misal_%0d_done got done=%b err=%b data=%h req=%b want 1 1 0 0", i, done, err, data_out, mem_bus.req);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_timeout();
    int cycles = 0;
    int late_done = 0;
    addr = 32'h500; size = SZ_WORD; start = 1'b1;
    tick();
    start = 1'b0;
    while (mem_bus.req === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
    end
    total_cnt++;
    if (cycles != 16) $display("[TB] FAIL timeout_req_len got %0d want 16", cycles);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b1 || err !== 1'b1)
      $display("[TB] FAIL timeout_done got done=%b err=%b want 1 1", done, err);
    else pass_cnt++;
    tick();
    mem_bus.ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_bus.ack = 1'b0;
      late_done += int'(done) + int'(busy);
    end
    total_cnt++;
    if (late_done != 0) $display("[TB] FAIL timeout_late_ack got %0d want 0", late_done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int reqs = 0;
    addr = 32'h600; size = SZ_WORD; start = 1'b1;
    tick();
    addr = 32'h400;
    tick();
    start = 1'b0;
    total_cnt++;
    if (mem_bus.addr !== 32'h600 || mem_bus.req !== 1'b1)
      $display("[TB] FAIL busy_addr got %h req=%b want 00000600 1", mem_bus.addr, mem_bus.req);
    else pass_cnt++;
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h12345678;
    tick();
    mem_bus.ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = int'(done);
    total_cnt++;
    if (data_out !== 32'h12345678) $display("[TB] FAIL busy_data got %h want 12345678", data_out);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      tick();
      dones += int'(done);
      reqs  += int'(mem_bus.req);
    end
    total_cnt++;
    if (dones != 1 || reqs != 0)
      $display("[TB] FAIL busy_single got dones=%0d reqs=%0d want 1 0", dones, reqs);
    else pass_cnt++;
  endtask

  task automatic test_lanes();
    logic [31:0] va [7] = '{32'h000, 32'h001, 32'h002, 32'h800, 32'h802, 32'h900, 32'h904};
    logic [1:0]  vs [7] = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_WORD, SZ_WORD};
    logic        vu [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] vr [7] = '{32'h000000F0, 32'h0000A500, 32'h007F0000, 32'h12348001,
                            32'h7FFF0000, 32'hDEADBEEF, 32'h80000001};
    logic [31:0] ve [7] = '{32'hFFFFFFF0, 32'h000000A5, 32'h0000007F, 32'hFFFF8001,
                            32'h00007FFF, 32'hDEADBEEF, 32'h80000001};
    logic [31:0] d;
    logic dn, er;
    for (int i = 0; i < 7; i++) begin
      run_load(va[i], vs[i], vu[i], vr[i], d, dn, er);
      total_cnt++;
      if (d !== ve[i] || dn !== 1'b1 || er !== 1'b0)
        $display("[TB] FAIL lane_%0d got data=%h done=%b err=%b want %h 1 0", i, d, dn, er, ve[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    int stray = 0;
    logic [31:0] d;
    logic dn, er;
    addr = 32'h700; size = SZ_BYTE; is_unsigned = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (mem_bus.req !== 1'b0 || busy !== 1'b0 || data_out !== 32'h0)
      $display("[TB] FAIL areset_clear got req=%b busy=%b data=%h want 0 0 0", mem_bus.req, busy, data_out);
    else pass_cnt++;
    #3;
    rst_n = 1'b1;
    mem_bus.ack = 1'b1;
    tick();
    mem_bus.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stray += int'(done);
      tick();
    end
    total_cnt++;
    if (stray != 0) $display("[TB] FAIL areset_no_done got %0d want 0", stray);
    else pass_cnt++;
    run_load(32'h701, SZ_BYTE, 1'b1, 32'h0000AB00, d, dn, er);
    total_cnt++;
    if (d !== 32'h000000AB || dn !== 1'b1 || er !== 1'b0)
      $display("[TB] FAIL areset_recover got data=%h done=%b err=%b want 000000ab 1 0", d, dn, er);
    else pass_cnt++;
  endtask

  initial begin
    mem_bus.ack = 1'b0;
    mem_bus.rdata = '0;
    test_reset();
    test_byte_signed();
    test_half_wait();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_lanes();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after %0d checks", total_cnt);
    $fatal(1, "[TB] watchdog");
  end

endmodule
